// File: rtl/ps2_pkg.sv
// Shared constants, LED bit layout and controller state encoding for the
// PS/2 keyboard LED command path.
package ps2_pkg;

  localparam logic [7:0] CMD_SET_LED = 8'hED;
  localparam logic [7:0] RSP_ACK     = 8'hFA;
  localparam logic [7:0] RSP_RESEND  = 8'hFE;

  localparam int unsigned LED_SCROLL_BIT = 0;
  localparam int unsigned LED_NUM_BIT    = 1;
  localparam int unsigned LED_CAPS_BIT   = 2;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_INHIBIT   = 2'd1,
    ST_TX        = 2'd2,
    ST_WAIT_RESP = 2'd3
  } state_e;

  // LED argument byte of the Set-LEDs command: upper five bits always zero.
  function automatic logic [7:0] led_byte(input logic [2:0] leds);
    return {5'b0_0000, leds};
  endfunction

endpackage

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 byte transmitter: clocked by the device's ps2_clk
// falling edges after the controller has issued the start bit.
module ps2_host_tx
  import ps2_pkg::*;
(
  input  logic       clk,
  input  logic       clr,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] tx_byte,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       data_oe,
  output logic       done,
  output logic       ack_ok
);

  logic [2:0] clk_sync_q, clk_sync_d;
  logic [1:0] dat_sync_q, dat_sync_d;
  logic       active_q, active_d;
  logic [3:0] edge_cnt_q, edge_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic       parity_q, parity_d;
  logic       data_oe_q, data_oe_d;
  logic       done_q, done_d;
  logic       ack_ok_q, ack_ok_d;
  logic       clk_fall;

  // Falling edge of the synchronized ps2_clk; data sampled at matching depth.
  assign clk_fall = clk_sync_q[2] & ~clk_sync_q[1];

  // Frame sequencing: start bit on start, then one action per device clock edge.
  always_comb begin
    clk_sync_d = {clk_sync_q[1:0], ps2_clk_in};
    dat_sync_d = {dat_sync_q[0], ps2_data_in};
    active_d   = active_q;
    edge_cnt_d = edge_cnt_q;
    shift_d    = shift_q;
    parity_d   = parity_q;
    data_oe_d  = data_oe_q;
    done_d     = 1'b0;
    ack_ok_d   = ack_ok_q;
    if (abort) begin
      active_d  = 1'b0;
      data_oe_d = 1'b0;
    end else if (start) begin
      active_d   = 1'b1;
      edge_cnt_d = '0;
      shift_d    = tx_byte;
      parity_d   = ~^tx_byte;
      data_oe_d  = 1'b1;
      ack_ok_d   = 1'b0;
    end else if (active_q && clk_fall) begin
      edge_cnt_d = edge_cnt_q + 4'd1;
      if (edge_cnt_q < 4'd8) begin
        data_oe_d = ~shift_q[0];
        shift_d   = {1'b0, shift_q[7:1]};
      end else if (edge_cnt_q == 4'd8) begin
        data_oe_d = ~parity_q;
      end else if (edge_cnt_q == 4'd9) begin
        data_oe_d = 1'b0;
      end else begin
        active_d  = 1'b0;
        data_oe_d = 1'b0;
        done_d    = 1'b1;
        ack_ok_d  = ~dat_sync_q[1];
      end
    end
  end

  // State registers; synchronizers reset to the idle-high line level.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      clk_sync_q <= '1;
      dat_sync_q <= '1;
      active_q   <= 1'b0;
      edge_cnt_q <= '0;
      shift_q    <= '0;
      parity_q   <= 1'b0;
      data_oe_q  <= 1'b0;
      done_q     <= 1'b0;
      ack_ok_q   <= 1'b0;
    end else begin
      clk_sync_q <= clk_sync_d;
      dat_sync_q <= dat_sync_d;
      active_q   <= active_d;
      edge_cnt_q <= edge_cnt_d;
      shift_q    <= shift_d;
      parity_q   <= parity_d;
      data_oe_q  <= data_oe_d;
      done_q     <= done_d;
      ack_ok_q   <= ack_ok_d;
    end
  end

  assign data_oe = data_oe_q;
  assign done    = done_q;
  assign ack_ok  = ack_ok_q;

endmodule

// File: rtl/ps2_led_ctrl.sv
// Set-LEDs command sequencer: sends 0xED plus the LED byte whenever the lock
// LED request changes, checks ACK/RESEND replies and owns the receive FIFO
// while the command is in flight.
module ps2_led_ctrl
  import ps2_pkg::*;
#(
  parameter int unsigned CLK_HZ      = 50_000_000,
  parameter int unsigned INHIBIT_CYC = 5000,
  parameter int unsigned TIMEOUT_CYC = 750000,
  parameter int unsigned MAX_RETRY   = 3
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  input  logic       led_caps,
  input  logic       led_num,
  input  logic       led_scroll,
  input  logic       rx_ready,
  input  logic [7:0] rx_data,
  output logic       rx_pop,
  output logic       rx_hold,
  output logic       rx_mask,
  output logic       busy,
  output logic       err
);

  // Inhibit counter is wide enough for the 100 us minimum at CLK_HZ as well.
  localparam int unsigned MIN_INHIBIT = CLK_HZ / 10_000;
  localparam int unsigned INH_MAX     = (INHIBIT_CYC > MIN_INHIBIT) ? INHIBIT_CYC : MIN_INHIBIT;
  localparam int unsigned INH_W       = $clog2(INH_MAX + 1);
  localparam int unsigned WD_W        = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned RT_W        = $clog2(MAX_RETRY + 1);

  state_e            state_q, state_d;
  logic [2:0]        sent_q, sent_d;
  logic [2:0]        snap_q, snap_d;
  logic              byte_idx_q, byte_idx_d;
  logic [RT_W-1:0]   retry_q, retry_d;
  logic [INH_W-1:0]  inh_q, inh_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic              err_q, err_d;
  logic              clk_oe_q, clk_oe_d;
  logic              pop_q;
  logic [2:0]        req;
  logic              wd_expired;
  logic              fail;
  logic              tx_start;
  logic [7:0]        tx_byte;
  logic              tx_done;
  logic              tx_ack_ok;

  assign wd_expired = (wd_q == WD_W'(TIMEOUT_CYC - 1));
  assign tx_byte    = byte_idx_q ? led_byte(snap_q) : CMD_SET_LED;

  // Requested LED vector in the command's bit layout.
  always_comb begin
    req                 = '0;
    req[LED_CAPS_BIT]   = led_caps;
    req[LED_NUM_BIT]    = led_num;
    req[LED_SCROLL_BIT] = led_scroll;
  end

  // Next-state, counters and FIFO arbitration.
  always_comb begin
    state_d    = state_q;
    sent_d     = sent_q;
    snap_d     = snap_q;
    byte_idx_d = byte_idx_q;
    retry_d    = retry_q;
    inh_d      = inh_q;
    wd_d       = wd_q;
    err_d      = err_q;
    rx_pop     = 1'b0;
    tx_start   = 1'b0;
    fail       = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (req != sent_q) begin
          snap_d     = req;
          byte_idx_d = 1'b0;
          retry_d    = '0;
          inh_d      = '0;
          wd_d       = '0;
          state_d    = ST_INHIBIT;
        end
      end
      ST_INHIBIT: begin
        wd_d = wd_q + 1'b1;
        if (inh_q == INH_W'(INHIBIT_CYC - 1)) begin
          tx_start = 1'b1;
          state_d  = ST_TX;
        end else begin
          inh_d = inh_q + 1'b1;
        end
      end
      ST_TX: begin
        wd_d = wd_q + 1'b1;
        if (tx_done) begin
          if (tx_ack_ok) state_d = ST_WAIT_RESP;
          else           fail    = 1'b1;
        end else if (wd_expired) begin
          fail = 1'b1;
        end
      end
      ST_WAIT_RESP: begin
        wd_d = wd_q + 1'b1;
        // A waiting byte takes priority over a same-cycle watchdog expiry.
        if (rx_ready && !pop_q) begin
          rx_pop = 1'b1;
          if (rx_data == RSP_ACK) begin
            if (!byte_idx_q) begin
              byte_idx_d = 1'b1;
              retry_d    = '0;
              inh_d      = '0;
              wd_d       = '0;
              state_d    = ST_INHIBIT;
            end else begin
              sent_d  = snap_q;
              err_d   = 1'b0;
              state_d = ST_IDLE;
            end
          end else if (rx_data == RSP_RESEND) begin
            fail = 1'b1;
          end
        end else if (wd_expired) begin
          fail = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Retry or give up; giving up commits the snapshot so it is not resent forever.
    if (fail) begin
      if (retry_q == RT_W'(MAX_RETRY - 1)) begin
        err_d   = 1'b1;
        sent_d  = snap_q;
        state_d = ST_IDLE;
      end else begin
        retry_d = retry_q + 1'b1;
        inh_d   = '0;
        wd_d    = '0;
        state_d = ST_INHIBIT;
      end
    end
    clk_oe_d = (state_d == ST_INHIBIT);
  end

  // Controller registers.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q    <= ST_IDLE;
      sent_q     <= '0;
      snap_q     <= '0;
      byte_idx_q <= 1'b0;
      retry_q    <= '0;
      inh_q      <= '0;
      wd_q       <= '0;
      err_q      <= 1'b0;
      clk_oe_q   <= 1'b0;
      pop_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      sent_q     <= sent_d;
      snap_q     <= snap_d;
      byte_idx_q <= byte_idx_d;
      retry_q    <= retry_d;
      inh_q      <= inh_d;
      wd_q       <= wd_d;
      err_q      <= err_d;
      clk_oe_q   <= clk_oe_d;
      pop_q      <= rx_pop;
    end
  end

  ps2_host_tx u_tx (
    .clk         (clk),
    .clr         (clr),
    .start       (tx_start),
    .abort       (fail),
    .tx_byte     (tx_byte),
    .ps2_clk_in  (ps2_clk_in),
    .ps2_data_in (ps2_data_in),
    .data_oe     (ps2_data_oe),
    .done        (tx_done),
    .ack_ok      (tx_ack_ok)
  );

  assign ps2_clk_oe = clk_oe_q;
  assign busy       = (state_q != ST_IDLE);
  assign rx_hold    = busy;
  assign rx_mask    = (state_q == ST_INHIBIT) || (state_q == ST_TX);
  assign err        = err_q;

endmodule

// File: tb/tb_ps2_led_ctrl.sv
// Directed bench for ps2_led_ctrl: a keyboard model clocks the host frames,
// a queue holds the expected wire frames, and a small FIFO model feeds replies.
module tb_ps2_led_ctrl;

  localparam int unsigned INH  = 20;
  localparam int unsigned TO   = 2000;
  localparam int unsigned HALF = 20;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic       led_caps = 1'b0, led_num = 1'b0, led_scroll = 1'b0;
  logic       dev_clk_pull = 1'b0, dev_data_pull = 1'b0;
  logic       ps2_clk_oe, ps2_data_oe, ps2_clk_in, ps2_data_in;
  logic       rx_ready, rx_pop, rx_hold, rx_mask, busy, err;
  logic [7:0] rx_data;

  logic [7:0]  fifo_mem [0:15];
  int unsigned fifo_head = 0, fifo_tail = 0;
  logic [7:0]  pop_log [0:31];
  int unsigned n_pops = 0;
  logic        pop_prev = 1'b0, pop_b2b = 1'b0, pop_empty = 1'b0;
  logic        watch_hold = 1'b0, hold_dropped = 1'b0;

  logic [8:0]  exp_q [$];
  int unsigned n_cmp = 0, n_err = 0;

  always #5 clk = ~clk;

  // Open-drain lines: low if either side pulls.
  assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_pull);
  assign ps2_data_in = ~(ps2_data_oe | dev_data_pull);
  assign rx_ready    = (fifo_head != fifo_tail);
  assign rx_data     = fifo_mem[fifo_head % 16];

  ps2_led_ctrl #(
    .CLK_HZ      (50_000_000),
    .INHIBIT_CYC (INH),
    .TIMEOUT_CYC (TO),
    .MAX_RETRY   (3)
  ) dut (
    .clk         (clk),
    .clr         (clr),
    .ps2_clk_in  (ps2_clk_in),
    .ps2_data_in (ps2_data_in),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe),
    .led_caps    (led_caps),
    .led_num     (led_num),
    .led_scroll  (led_scroll),
    .rx_ready    (rx_ready),
    .rx_data     (rx_data),
    .rx_pop      (rx_pop),
    .rx_hold     (rx_hold),
    .rx_mask     (rx_mask),
    .busy        (busy),
    .err         (err)
  );

  // FIFO consumer side and pop-protocol monitor.
  always @(posedge clk) begin
    if (rx_pop) begin
      pop_log[n_pops % 32] <= rx_data;
      n_pops    <= n_pops + 1;
      fifo_head <= fifo_head + 1;
      if (fifo_head == fifo_tail) pop_empty <= 1'b1;
      if (pop_prev) pop_b2b <= 1'b1;
    end
    pop_prev <= rx_pop;
  end

  always @(negedge clk) begin
    if (watch_hold && rx_hold !== 1'b1) hold_dropped <= 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_rx(input logic [7:0] v);
    fifo_mem[fifo_tail % 16] = v;
    fifo_tail = fifo_tail + 1;
  endtask

  // Keyboard side of a host-to-device frame; stops with clock held low after n_edges < 11.
  task automatic dev_frame(input int unsigned n_edges, output logic [7:0] b,
                           output logic par, output logic stop, output logic ok);
    int unsigned budget = 0;
    b = '0; par = 1'b0; stop = 1'b0; ok = 1'b0;
    while (!(ps2_data_oe === 1'b1 && ps2_clk_oe === 1'b0) && budget < 4000) begin
      @(negedge clk);
      budget++;
    end
    if (budget >= 4000) return;
    ok = 1'b1;
    for (int unsigned i = 1; i <= n_edges; i++) begin
      repeat (HALF) @(negedge clk);
      if (i == 11) dev_data_pull = 1'b1;
      dev_clk_pull = 1'b1;
      repeat (HALF) @(negedge clk);
      if (i <= 8)       b[i-1] = ps2_data_in;
      else if (i == 9)  par    = ps2_data_in;
      else if (i == 10) stop   = ps2_data_in;
      if (i == n_edges && n_edges < 11) return;
      dev_clk_pull  = 1'b0;
      dev_data_pull = 1'b0;
    end
  endtask

  task automatic frame_and_check(input string tag);
    logic [7:0] b;
    logic       par, stop, ok;
    logic [8:0] e;
    dev_frame(11, b, par, stop, ok);
    check({tag, "_started"}, ok, 1'b1);
    if (exp_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
      return;
    end
    e = exp_q.pop_front();
    check({tag, "_byte"}, b, e[7:0]);
    check({tag, "_parity"}, par, e[8]);
    check({tag, "_stop"}, stop, 1'b1);
  endtask

  task automatic wait_idle(input string tag, input int unsigned limit);
    int unsigned n = 0;
    while (busy === 1'b1 && n < limit) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_busy_fall"}, busy, 1'b0);
  endtask

  task automatic reset_dut();
    led_caps = 1'b0;
    clr = 1'b1;
    dev_clk_pull = 1'b0;
    dev_data_pull = 1'b0;
    repeat (3) @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int unsigned cyc;
    int unsigned p0;
    logic [7:0]  b;
    logic        par, stop, ok;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_clk_oe", ps2_clk_oe, 1'b0);
    check("rst_data_oe", ps2_data_oe, 1'b0);
    check("rst_busy", {busy, rx_hold, rx_mask, rx_pop, err}, 5'b0);
    clr = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_busy", busy, 1'b0);

    // 1: plain ED / 04 exchange
    led_caps = 1'b1;
    exp_q.push_back({1'b1, 8'hED});
    exp_q.push_back({1'b0, 8'h04});
    @(posedge clk); #1;
    check("t1_start_clk_oe", ps2_clk_oe, 1'b1);
    check("t1_start_busy", {busy, rx_hold, rx_mask}, 3'b111);
    @(negedge clk);
    frame_and_check("t1_f0");
    check("t1_wait_resp", {busy, rx_mask, ps2_data_oe}, 3'b100);
    push_rx(8'hFA);
    frame_and_check("t1_f1");
    push_rx(8'hFA);
    wait_idle("t1", 500);
    check("t1_err", err, 1'b0);
    check("t1_lines", {ps2_clk_oe, ps2_data_oe, rx_hold}, 3'b000);
    repeat (100) @(negedge clk);
    check("t1_no_restart", busy, 1'b0);

    // 2: RESEND on the LED byte
    reset_dut();
    p0 = n_pops;
    led_caps = 1'b1;
    exp_q.push_back({1'b1, 8'hED});
    exp_q.push_back({1'b0, 8'h04});
    exp_q.push_back({1'b0, 8'h04});
    frame_and_check("t2_f0");
    push_rx(8'hFA);
    frame_and_check("t2_f1");
    push_rx(8'hFE);
    frame_and_check("t2_f1_retry");
    push_rx(8'hFA);
    wait_idle("t2", 500);
    check("t2_err", err, 1'b0);
    check("t2_pops", n_pops - p0, 32'd3);

    // 3: keyboard never clocks
    reset_dut();
    led_caps = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      if (busy === 1'b1) cyc++;
    end while (busy === 1'b1 && cyc < 4 * TO);
    check("t3_busy", busy, 1'b0);
    check("t3_duration", (cyc + 2 >= 3 * TO) && (cyc <= 3 * TO + 2), 1'b1);
    check("t3_err", err, 1'b1);
    check("t3_lines", {ps2_clk_oe, ps2_data_oe}, 2'b00);
    repeat (200) @(negedge clk);
    check("t3_no_restart", {busy, err}, 2'b01);

    // 4: stray scancode ahead of ACK
    reset_dut();
    check("t4_err_cleared", err, 1'b0);
    p0 = n_pops;
    led_caps = 1'b1;
    exp_q.push_back({1'b1, 8'hED});
    exp_q.push_back({1'b0, 8'h04});
    @(negedge clk);
    watch_hold = 1'b1;
    frame_and_check("t4_f0");
    push_rx(8'h1C);
    push_rx(8'hFA);
    frame_and_check("t4_f1");
    watch_hold = 1'b0;
    check("t4_hold_kept", hold_dropped, 1'b0);
    check("t4_pop0", pop_log[p0 % 32], 8'h1C);
    check("t4_pop1", pop_log[(p0 + 1) % 32], 8'hFA);
    push_rx(8'hFA);
    wait_idle("t4", 500);
    check("t4_err", err, 1'b0);

    // 5: asynchronous clear in the middle of the data bits
    reset_dut();
    led_caps = 1'b1;
    dev_frame(2, b, par, stop, ok);
    check("t5_started", ok, 1'b1);
    check("t5_bit1_low", ps2_data_oe, 1'b1);
    #2 clr = 1'b1;
    #1;
    check("t5_async_release", {ps2_clk_oe, ps2_data_oe, busy}, 3'b000);
    @(negedge clk);
    dev_clk_pull = 1'b0;
    clr = 1'b0;
    exp_q.push_back({1'b1, 8'hED});
    exp_q.push_back({1'b0, 8'h04});
    frame_and_check("t5_f0");
    push_rx(8'hFA);
    frame_and_check("t5_f1");
    push_rx(8'hFA);
    wait_idle("t5", 500);
    check("t5_err", err, 1'b0);

    // Protocol-wide checks
    check("sb_drained", exp_q.size(), 32'd0);
    check("pop_not_empty", pop_empty, 1'b0);
    check("pop_spacing", pop_b2b, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
